regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised integer register file with NUM_RD combinational read ports, one synchronous write port, and a per-register busy scoreboard.
- Serves as the decode/writeback register file of the RISC-V core.
- The scoreboard lets issue logic track outstanding writes (e.g. multi-cycle loads) and stall on RAW/WAW hazards.
- Register 0 is hardwired to zero.

Parameters:
XLEN, 32, data width in bits
NUM_REGS, 32, number of architectural registers (power of 2, >=2)
NUM_RD, 2, number of read ports (1..4)
AW, $clog2(NUM_REGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NUM_RD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NUM_RD  1 = addressed register has an outstanding write
wr_en  in  1  writeback valid
wr_addr  in  AW  writeback destination
wr_data  in  XLEN  writeback data
wb_spurious  out  1  registered pulse: last-cycle write hit a non-busy register (x0 excluded)
iss_en  in  1  issue request: mark iss_rd busy
iss_rd  in  AW  destination of issuing instruction
iss_ready  out  1  combinational: iss_rd == 0 or register not busy
flush  in  1  clear all busy bits (pipeline flush)
pend_cnt  out  AW+1  registered count of busy registers

Behaviour:
- Reset (reset==0, asynchronous): all registers 0, all busy bits 0, pend_cnt 0, wb_spurious 0. rd_data forced to 0 and rd_busy to 0 while reset is low.
- Reads are combinational, zero latency:
  - rd_data[i] = regs[rd_addr[i]].
  - rd_busy[i] = busy[rd_addr[i]].
  - Address 0 always returns 0 and is never busy.
- Write:
  - At posedge, if wr_en && wr_addr != 0, regs[wr_addr] <= wr_data.
  - Writes to x0 are discarded silently.
  - Write data is visible on the read ports from the next cycle (unless bypass is enabled).
- Scoreboard, per register r != 0, evaluated at posedge in priority order:
  1. flush: busy[r] <= 0 for all r. iss_en is ignored in a flush cycle. The write itself still occurs.
  2. iss_en && iss_ready && iss_rd == r: busy[r] <= 1. Set beats a same-cycle clear on the same r, because the new producer is younger.
  3. wr_en && wr_addr == r: busy[r] <= 0.
- iss_en with iss_ready == 0 (WAW on a busy register): request ignored, no state change. The issuer must hold and retry.
- iss_rd == 0: iss_ready = 1, no busy bit set.
- wb_spurious <= wr_en && wr_addr != 0 && !busy[wr_addr] (value before update). Held 1 cycle. The write still commits.
- pend_cnt <= popcount of next-state busy vector. Range 0..NUM_REGS-1.
- Multiple read ports may address the same register; all return identical data.
- Reset asserted mid-operation wipes data and scoreboard immediately. The first edge after deassertion behaves as from clean state.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: a read port whose rd_addr equals wr_addr while wr_en==1 and wr_addr!=0 returns wr_data combinationally in the same cycle, and its rd_busy reads 0 unless the same-cycle issue sets it. This gives write-to-read forwarding through the register file.
- Undefined: such a read returns the old register value and the current busy bit. Forwarding is left to the pipeline.

Decomposition:
- Shared package regfile_pkg:
  - REG_ZERO address constant.
  - Default XLEN/NUM_REGS localparams.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef xdata_t (logic [XLEN-1:0]).
- One sub-module: regfile_scoreboard. It owns the busy vector, the priority logic, wb_spurious and the popcount. The top holds the storage array and the read muxes.

Test Plan:
- Reset, then read all registers on both ports -> rd_data 0, rd_busy 0, pend_cnt 0, iss_ready 1.
- Write x5=0x0000_00AA, next cycle read rd_addr0=5 -> 0xAA. Write x0=0xFFFF_FFFF -> x0 still reads 0.
- Issue rd=3 (cycle n), writeback x3=0x1234 at cycle n+4 -> rd_busy=1 and pend_cnt=1 during n+1..n+4, then rd_busy=0 and pend_cnt=0 at n+5. wb_spurious stays 0.
- With x7 busy, same-cycle iss_en(rd=7) and wr_en(wr_addr=7) -> iss_ready=0, so the issue is ignored and busy[7] clears. Repeat with x7 not busy -> busy[7] ends 1 (set wins) and wb_spurious=1.
- Issue rd=1,2,4 over three cycles, then flush with iss_en(rd=9) -> pend_cnt 3 then 0, busy[9] stays 0.
- REGFILE_WR_BYPASS_EN: wr_en x6=0xDEAD_BEEF and rd_addr1=6 in the same cycle -> rd_data1=0xDEADBEEF that cycle. Without the macro -> old value, new value next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file and its scoreboard.
// Optional feature macro: REGFILE_WR_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

  // Default geometry of the RISC-V integer register file
  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int AW_DEFAULT       = $clog2(NUM_REGS_DEFAULT);

  // Architectural zero register, hardwired to 0 and never busy
  localparam int REG_ZERO = 0;

  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xdata_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file: tracks registers with an
// outstanding write, flags writebacks to non-busy registers and keeps a
// registered count of pending registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEFAULT,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                iss_ready,
  output logic                wb_spurious,
  output logic [AW:0]         pend_cnt
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [AW:0]         pendCnt_q, pendCnt_d;
  logic                wbSpurious_q, wbSpurious_d;
  logic                issFire;

  // An issue may only proceed when its destination has no outstanding
  // write; x0 never blocks because it can never become busy.
  always_comb begin
    iss_ready = (iss_rd == AW'(REG_ZERO)) || !busy_q[iss_rd];
    issFire   = iss_en && iss_ready && !flush;
  end

  // Next busy vector: flush wins, then a new producer sets its bit (it is
  // younger than any same-cycle writeback), then a writeback clears it.
  always_comb begin
    busy_d    = busy_q;
    pendCnt_d = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (issFire && iss_rd == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if (wr_en && wr_addr == AW'(r)) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pendCnt_d = pendCnt_d + (AW+1)'(busy_d[r]);
    end
    wbSpurious_d = wr_en && (wr_addr != AW'(REG_ZERO)) && !busy_q[wr_addr];
  end

  // Scoreboard state, count and spurious-writeback pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q       <= '0;
      pendCnt_q    <= '0;
      wbSpurious_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      pendCnt_q    <= pendCnt_d;
      wbSpurious_q <= wbSpurious_d;
    end
  end

  assign busy        = busy_q;
  assign pend_cnt    = pendCnt_q;
  assign wb_spurious = wbSpurious_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NUM_RD combinational read ports, one write
// port and a busy scoreboard. x0 reads as zero and is never busy.
// Optional feature macro: REGFILE_WR_BYPASS_EN (same-cycle write forwarding).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NUM_REGS = NUM_REGS_DEFAULT,
  parameter  int NUM_RD   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  output logic                   wb_spurious,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd,
  output logic                   iss_ready,
  input  logic                   flush,
  output logic [AW:0]            pend_cnt
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .iss_en      (iss_en),
    .iss_rd      (iss_rd),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .busy        (busy),
    .iss_ready   (iss_ready),
    .wb_spurious (wb_spurious),
    .pend_cnt    (pend_cnt)
  );

  // Register storage: writes to x0 are dropped so it stays zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en && wr_addr != AW'(REG_ZERO)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read muxes: zero while in reset or for x0, optional write forwarding
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (reset && rd_addr[i*AW +: AW] != AW'(REG_ZERO)) begin
        rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
        rd_busy[i]              = busy[rd_addr[i*AW +: AW]];
`ifdef REGFILE_WR_BYPASS_EN
        if (wr_en && wr_addr == rd_addr[i*AW +: AW]) begin
          rd_data[i*XLEN +: XLEN] = wr_data;
          rd_busy[i]              = !flush && iss_en && iss_ready &&
                                    (iss_rd == rd_addr[i*AW +: AW]);
        end
`endif
      end
    end
  end

endmodule
